// File: rtl/vga_text_wr_ctrl.sv
// Write-port controller for the 80x60 text buffer: CPU stores take strict
// priority over a hardware fill engine (clear screen / rows / attribute fill).
module vga_text_wr_ctrl #(
    parameter int ROW_WORDS = 40,
    parameter int ROWS      = 60,
    parameter int ADDR_W    = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    input  logic              i_fill_start,
    input  logic              i_fill_abort,
    input  logic [31:0]       i_fill_word,
    input  logic [5:0]        i_fill_row,
    input  logic [6:0]        i_fill_nrows,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_fill_done,
    output logic              o_oob_err
);

    // state  | meaning
    // S_IDLE | waiting for a fill start; CPU writes pass through
    // S_FILL | writing the latched word at ptr whenever the CPU is quiet
    // S_DONE | last fill word issued; busy drops, back to idle
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] MEM_WORDS = ADDR_W'(ROWS * ROW_WORDS);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_addr;
    logic [31:0]       fill_word;

    logic              cpu_req;
    logic              cpu_oob;
    logic [7:0]        end_row_sum;
    logic [7:0]        end_row;
    logic [ADDR_W-1:0] start_calc;
    logic [ADDR_W-1:0] end_calc;

    // row*40 as (row<<5)+(row<<3); end row clipped to the last text row
    always_comb begin
        cpu_req     = (i_cpu_we != 4'h0);
        cpu_oob     = (i_cpu_addr >= MEM_WORDS);
        end_row_sum = {2'b00, i_fill_row} + {1'b0, i_fill_nrows};
        end_row     = (end_row_sum > 8'(ROWS)) ? 8'(ROWS) : end_row_sum;
        start_calc  = (ADDR_W'(i_fill_row) << 5) + (ADDR_W'(i_fill_row) << 3);
        end_calc    = (ADDR_W'(end_row) << 5) + (ADDR_W'(end_row) << 3);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            end_addr    <= '0;
            fill_word   <= '0;
            o_mem_we    <= '0;
            o_mem_waddr <= '0;
            o_mem_wdata <= '0;
            o_busy      <= 1'b0;
            o_fill_done <= 1'b0;
            o_oob_err   <= 1'b0;
        end else begin
            o_mem_we    <= '0;
            o_fill_done <= 1'b0;

            if (cpu_req) begin
                if (cpu_oob) begin
                    o_oob_err <= 1'b1;
                end else begin
                    o_mem_we    <= i_cpu_we;
                    o_mem_waddr <= i_cpu_addr;
                    o_mem_wdata <= i_cpu_wdata;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_fill_start) begin
                        fill_word <= i_fill_word;
                        end_addr  <= end_calc;
                        ptr       <= start_calc;
                        if (start_calc >= end_calc) begin
                            o_fill_done <= 1'b1;
                        end else begin
                            state  <= S_FILL;
                            o_busy <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (i_fill_abort) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else if (!cpu_req) begin
                        o_mem_we    <= 4'hF;
                        o_mem_waddr <= ptr;
                        o_mem_wdata <= fill_word;
                        ptr         <= ptr + ADDR_W'(1);
                        if (ptr + ADDR_W'(1) == end_addr) begin
                            state       <= S_DONE;
                            o_fill_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_wr_ctrl.sv
// Directed bench for vga_text_wr_ctrl: CPU pass-through, fills, clipping,
// CPU interleave, abort, out-of-range writes and async reset.
module tb_vga_text_wr_ctrl;

    logic        clk;
    logic        i_rst;
    logic [3:0]  i_cpu_we;
    logic [11:0] i_cpu_addr;
    logic [31:0] i_cpu_wdata;
    logic        i_fill_start;
    logic        i_fill_abort;
    logic [31:0] i_fill_word;
    logic [5:0]  i_fill_row;
    logic [6:0]  i_fill_nrows;
    logic [3:0]  o_mem_we;
    logic [11:0] o_mem_waddr;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_fill_done;
    logic        o_oob_err;

    int errors = 0;
    int checks = 0;

    vga_text_wr_ctrl #(.ROW_WORDS(40), .ROWS(60), .ADDR_W(12)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_wdata  (i_cpu_wdata),
        .i_fill_start (i_fill_start),
        .i_fill_abort (i_fill_abort),
        .i_fill_word  (i_fill_word),
        .i_fill_row   (i_fill_row),
        .i_fill_nrows (i_fill_nrows),
        .o_mem_we     (o_mem_we),
        .o_mem_waddr  (o_mem_waddr),
        .o_mem_wdata  (o_mem_wdata),
        .o_busy       (o_busy),
        .o_fill_done  (o_fill_done),
        .o_oob_err    (o_oob_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one fill and checks every output cycle. CPU writes (we=4'hC, addr ca)
    // are injected on cycles c0/c1/c2 (-1 = unused); the fill must yield on each.
    task automatic fill_run(input logic [5:0] row, input logic [6:0] nrows,
                            input logic [31:0] word, input int exp_start,
                            input int exp_n, input int c0, input int c1,
                            input int c2, input logic [11:0] ca,
                            input logic with_abort);
        int ptr;
        int ncpu;
        int total;
        logic cpu;
        i_fill_row   = row;
        i_fill_nrows = nrows;
        i_fill_word  = word;
        i_fill_start = 1'b1;
        i_fill_abort = with_abort;
        step();
        i_fill_start = 1'b0;
        i_fill_abort = 1'b0;
        i_fill_word  = 32'hDEAD_BEEF;
        chk("fill_busy_start", 32'(o_busy), 32'd1);
        chk("fill_we_start", 32'(o_mem_we), 32'h0);
        ptr   = exp_start;
        ncpu  = (c0 >= 0 ? 1 : 0) + (c1 >= 0 ? 1 : 0) + (c2 >= 0 ? 1 : 0);
        total = exp_n + ncpu;
        for (int cyc = 0; cyc < total; cyc++) begin
            cpu = (cyc == c0) || (cyc == c1) || (cyc == c2);
            i_cpu_we    = cpu ? 4'hC : 4'h0;
            i_cpu_addr  = ca;
            i_cpu_wdata = 32'hA5A5_0000 + 32'(cyc);
            step();
            i_cpu_we = 4'h0;
            if (cpu) begin
                if (ca < 12'd2400) begin
                    chk("cpu_we", 32'(o_mem_we), 32'hC);
                    chk("cpu_addr", 32'(o_mem_waddr), 32'(ca));
                    chk("cpu_data", o_mem_wdata, 32'hA5A5_0000 + 32'(cyc));
                end else begin
                    chk("oob_we", 32'(o_mem_we), 32'h0);
                    chk("oob_err", 32'(o_oob_err), 32'd1);
                end
            end else begin
                chk("fill_we", 32'(o_mem_we), 32'hF);
                chk("fill_addr", 32'(o_mem_waddr), 32'(ptr));
                chk("fill_data", o_mem_wdata, word);
                ptr++;
            end
            chk("fill_done", 32'(o_fill_done), (cyc == total - 1) ? 32'd1 : 32'd0);
        end
        step();
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("post_done", 32'(o_fill_done), 32'd0);
        chk("post_we", 32'(o_mem_we), 32'h0);
    endtask

    task automatic zero_fill(input logic [5:0] row, input logic [6:0] nrows);
        i_fill_row   = row;
        i_fill_nrows = nrows;
        i_fill_word  = 32'h1234_5678;
        i_fill_start = 1'b1;
        step();
        i_fill_start = 1'b0;
        chk("zero_done", 32'(o_fill_done), 32'd1);
        chk("zero_we", 32'(o_mem_we), 32'h0);
        chk("zero_busy", 32'(o_busy), 32'd0);
        step();
        chk("zero_done_clr", 32'(o_fill_done), 32'd0);
        chk("zero_we2", 32'(o_mem_we), 32'h0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_cpu_we     = 4'h0;
        i_cpu_addr   = 12'd0;
        i_cpu_wdata  = 32'd0;
        i_fill_start = 1'b0;
        i_fill_abort = 1'b0;
        i_fill_word  = 32'd0;
        i_fill_row   = 6'd0;
        i_fill_nrows = 7'd0;
        step();
        step();
        chk("rst_we", 32'(o_mem_we), 32'h0);
        chk("rst_addr", 32'(o_mem_waddr), 32'h0);
        chk("rst_data", o_mem_wdata, 32'h0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_fill_done), 32'd0);
        chk("rst_oob", 32'(o_oob_err), 32'd0);
        i_rst = 1'b0;
        step();

        // Abort while idle does nothing
        i_fill_abort = 1'b1;
        step();
        i_fill_abort = 1'b0;
        chk("idle_abort_busy", 32'(o_busy), 32'd0);
        chk("idle_abort_done", 32'(o_fill_done), 32'd0);

        // Plain CPU write
        i_cpu_we    = 4'h3;
        i_cpu_addr  = 12'd5;
        i_cpu_wdata = 32'h1F41_0F41;
        step();
        i_cpu_we = 4'h0;
        chk("cpu1_we", 32'(o_mem_we), 32'h3);
        chk("cpu1_addr", 32'(o_mem_waddr), 32'd5);
        chk("cpu1_data", o_mem_wdata, 32'h1F41_0F41);
        chk("cpu1_busy", 32'(o_busy), 32'd0);
        step();
        chk("cpu1_we_off", 32'(o_mem_we), 32'h0);
        chk("cpu1_addr_hold", 32'(o_mem_waddr), 32'd5);

        // Full-screen clear
        fill_run(6'd0, 7'd60, 32'h0F20_0F20, 0, 2400, -1, -1, -1, 12'd0, 1'b0);

        // Clipped fill; abort alongside start must lose to start
        fill_run(6'd58, 7'd10, 32'h2E41_2E41, 2320, 80, -1, -1, -1, 12'd0, 1'b1);

        // Empty fills
        zero_fill(6'd60, 7'd5);
        zero_fill(6'd3, 7'd0);

        // CPU traffic during a single-row fill: 40 + 3 cycles
        fill_run(6'd1, 7'd1, 32'h7E30_7E30, 40, 40, 5, 6, 20, 12'd7, 1'b0);

        // Abort after 10 writes; a start while busy is ignored
        i_fill_row   = 6'd2;
        i_fill_nrows = 7'd2;
        i_fill_word  = 32'h4F58_4F58;
        i_fill_start = 1'b1;
        step();
        i_fill_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                i_fill_row   = 6'd0;
                i_fill_nrows = 7'd60;
                i_fill_word  = 32'h0;
                i_fill_start = 1'b1;
            end
            step();
            i_fill_start = 1'b0;
            chk("abort_fill_we", 32'(o_mem_we), 32'hF);
            chk("abort_fill_addr", 32'(o_mem_waddr), 32'd80 + 32'(i));
            chk("abort_fill_data", o_mem_wdata, 32'h4F58_4F58);
        end
        i_fill_abort = 1'b1;
        step();
        i_fill_abort = 1'b0;
        chk("abort_we", 32'(o_mem_we), 32'h0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_quiet_we", 32'(o_mem_we), 32'h0);
            chk("abort_no_done", 32'(o_fill_done), 32'd0);
        end
        fill_run(6'd59, 7'd1, 32'h0C21_0C21, 2360, 40, -1, -1, -1, 12'd0, 1'b0);

        // Out-of-range CPU write during a fill: dropped, sticky error, fill yields
        fill_run(6'd0, 7'd1, 32'h1111_2222, 0, 40, 3, -1, -1, 12'd2400, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("oob_sticky", 32'(o_oob_err), 32'd1);

        // Async reset mid-fill
        i_fill_row   = 6'd0;
        i_fill_nrows = 7'd60;
        i_fill_word  = 32'h0F20_0F20;
        i_fill_start = 1'b1;
        step();
        i_fill_start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("pre_rst_we", 32'(o_mem_we), 32'hF);
        chk("pre_rst_addr", 32'(o_mem_waddr), 32'd19);
        #5;
        i_rst = 1'b1;
        #1;
        chk("arst_we", 32'(o_mem_we), 32'h0);
        chk("arst_addr", 32'(o_mem_waddr), 32'h0);
        chk("arst_data", o_mem_wdata, 32'h0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_oob", 32'(o_oob_err), 32'd0);
        step();
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_we", 32'(o_mem_we), 32'h0);
            chk("post_rst_done", 32'(o_fill_done), 32'd0);
            chk("post_rst_busy", 32'(o_busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_text_wr_ctrl.md
Name: vga_text_wr_ctrl

Overview:
- Write-side controller for the 80x60 character text buffer. The buffer holds 2400 words; each 32-bit word holds two cells of {bg[3:0], fg[3:0], char[7:0]}, with the even cell in the low half.
- Arbitrates the CPU store path against an internal hardware fill engine (clear screen / clear rows / fill with attribute) and drives the buffer's single write port.
- Sits between the memory-mapped VGA window decode and the text memory write port (byte enables, 12-bit word address, 32-bit data).

Parameters:
- ROW_WORDS, 40, words per text row (80 cols / 2 cells per word)
- ROWS, 60, text rows
- ADDR_W, 12, word address width of the text memory

Ports:
- i_clk  in  1  system/pixel clock
- i_rst  in  1  asynchronous active-high reset
- i_cpu_we  in  4  CPU byte enables; nonzero = write request this cycle
- i_cpu_addr  in  ADDR_W  CPU word address
- i_cpu_wdata  in  32  CPU write data
- i_fill_start  in  1  one-cycle pulse: start fill
- i_fill_abort  in  1  one-cycle pulse: abort running fill
- i_fill_word  in  32  word written to every filled location
- i_fill_row  in  6  first row to fill
- i_fill_nrows  in  7  number of rows to fill (0..64)
- o_mem_we  out  4  memory byte enables
- o_mem_waddr  out  ADDR_W  memory word address
- o_mem_wdata  out  32  memory write data
- o_busy  out  1  fill engine active
- o_fill_done  out  1  one-cycle pulse on fill completion
- o_oob_err  out  1  sticky: CPU write to address >= ROWS*ROW_WORDS dropped; cleared only by reset

Behaviour:
- Reset: all outputs 0; FSM in IDLE; fill pointer, end address and latched fill word cleared. Reset mid-fill stops it immediately; no done pulse.
- Memory outputs are registered. A write accepted in cycle N appears on o_mem_* in cycle N+1. When nothing is written, o_mem_we=0; address and data are don't-care but hold their last value.
- The CPU is never stalled and has strict priority. In any cycle with i_cpu_we!=0:
  - the CPU write goes out;
  - the fill engine does not advance that cycle.
- CPU out-of-range write (addr >= 2400): o_mem_we=0, o_oob_err set, and the fill engine still yields that cycle.
- FSM IDLE:
  - On i_fill_start, compute start = i_fill_row*ROW_WORDS and end = min(i_fill_row+i_fill_nrows, ROWS)*ROW_WORDS, and latch i_fill_word.
  - If start >= end (nrows=0 or row >= ROWS): no writes; pulse o_fill_done next cycle; stay IDLE.
  - Otherwise go to FILL with ptr=start and o_busy=1 from the next cycle.
- FSM FILL: each cycle without a CPU write, issue we=4'hF, addr=ptr, data=latched word, then ptr++. When the word at end-1 is issued, go to DONE.
- FSM DONE: pulse o_fill_done for one cycle, drop o_busy, return to IDLE. The last fill write and the done pulse appear on outputs in the same cycle.
- i_fill_start while busy: ignored.
- i_fill_abort in FILL: go to IDLE next cycle with no further fill writes and no done pulse. In IDLE it has no effect.
- Simultaneous i_fill_abort and i_fill_start in IDLE: start wins.
- Arithmetic: row*40 computed as (row<<5)+(row<<3) in ADDR_W bits. The end clip at 2400 guarantees the pointer never wraps.
- Throughput: a full-screen clear with no CPU traffic takes 2400 write cycles + 1 (DONE) after the start cycle.

Test Plan:
- Reset release, then CPU write we=4'h3, addr=12'd5, data=32'h1F41_0F41 -> next cycle o_mem_we=4'h3, addr 5, same data; o_busy=0.
- fill_start row=0, nrows=60, word=32'h0F20_0F20, no CPU traffic:
  - 2400 consecutive writes, addresses 0..2399, we=4'hF;
  - o_fill_done pulses once, in the cycle addr 2399 appears;
  - o_busy then 0.
- fill row=58, nrows=10 -> clipped to addresses 2320..2399 (80 writes), then done.
- fill row=60 nrows=5, and separately row=3 nrows=0 -> zero writes; o_fill_done one cycle after start.
- During fill row=1, nrows=1 (addresses 40..79), CPU writes addr 7 on 3 cycles:
  - CPU writes appear on exactly those cycles;
  - fill addresses remain contiguous with no gaps or repeats;
  - fill completes 3 cycles later than without CPU traffic.
- Mid-fill cases:
  - i_fill_abort after 10 fill writes -> no further fill writes and no done pulse; a new fill_start is accepted.
  - Async i_rst mid-fill -> outputs 0 immediately.
  - CPU write to addr 2400 -> o_mem_we=0 and o_oob_err=1 until reset.
